ntt_out_reorder: RTL and testbench
==================================

# ntt_out_reorder

Downstream consumer of the pipelined NTT output stream. It absorbs one coefficient pair per `in_en` cycle in the NTT's bit-reversed pair order and buffers each polynomial in one of two ping-pong banks. It replays each polynomial in natural pair order over a valid/ready handshake. The output format is the same pair format the NTT front end consumes, so results can go straight to the next NTT/INTT pass or to the pointwise multiplier.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH ``, coefficient width.
- `STAGE_CNT`, default `` `NTT_STAGE_CNT ``, log2 of coefficients per polynomial (N = 2^STAGE_CNT, P = N/2 pairs).
- `ADDR_W`, derived, = STAGE_CNT-1. Must not be overridden.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — reset, synchronous, active-high.
- `in_en` in 1 — input pair valid; driven by the NTT `out_en`; no backpressure upstream.
- `in` in 2×DATA_WIDTH — unpacked `[2]`: in[0] is coefficient r, in[1] is coefficient r+P.
- `out_valid` out 1 — output pair valid.
- `out_ready` in 1 — consumer accepts the pair.
- `out` out 2×DATA_WIDTH — unpacked `[2]`: out[0] = a[j], out[1] = a[j+P].
- `out_last` out 1 — high with pair j = P-1.
- `overflow` out 1 — sticky; an input pair was dropped.

## Operation
- **Input order.** The k-th accepted pair of a polynomial (k = 0..P-1) carries r = bitrev_ADDR_W(k): in[0]=a[r], in[1]=a[r+P].
- **Writes.**
  - Write address = bitrev(k) into the current write bank.
  - The write counter k advances only on accepted `in_en`; gaps in `in_en` are allowed.
  - When k wraps at P-1, the bank goes FULL and the write pointer toggles to the other bank.
- **Reads.** Read address j = 0..P-1, natural order, from the current read bank. A bank drains only when FULL and all of it is read.
- **Bank states.** Each bank is EMPTY → FILLING (first accepted write) → FULL (write of pair P-1) → DRAINING (first RAM read issued) → EMPTY (RAM read of j=P-1 issued).
- **Overflow.** `in_en` while the write bank is not EMPTY or FILLING means the pair is dropped and `overflow` is set; k does not advance. The drop is intended to be unreachable in a correctly provisioned system.
- **Same-cycle bank release.** `in_en` in the same cycle a bank transitions to EMPTY is still treated as overflow; acceptance starts the next cycle.
- **Output pipeline.** RAM read stage plus output register, credit-tracked so at most 2 pairs are in flight. Sustains 1 pair/cycle while `out_ready`=1.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, `out` and `out_last` hold stable.
- **Data path.** No arithmetic; data passes bit-exact.
- **Reset values.**
  - Outputs: `out_valid`=0, `out_last`=0, `out`='{0,0}, `overflow`=0.
  - Internal: both banks EMPTY, both bank pointers = bank 0, k=0, j=0.
  - RAM contents are not reset.
- **Reset mid-operation.** Discards all buffered and partial polynomials. The first `in_en` after `rst` drops is pair k=0.

## Timing
- **Write.** In the cycle `in_en`=1, the RAM write lands on that clock edge.
- **Fill-to-output latency.** If pair P-1 is written on edge t, the RAM read of j=0 issues at edge t+1. `out_valid` with pair 0 is asserted after edge t+2 (2 cycles), independent of `out_ready`.
- **Throughput.** With `out_ready`=1 continuously, pairs j=0..P-1 emerge on P consecutive cycles. Back-to-back polynomials (second bank already FULL) continue with no bubble.
- **Handshake.** A pair transfers on an edge where `out_valid`&&`out_ready`. `out_valid` may not drop without a transfer.
- **Write-bank release under sustained input.** The write bank is released P cycles after its drain starts, when `out_ready` is held high. Sustained input at 1 pair/cycle is therefore lossless iff the consumer keeps `out_ready` high.

## Structure
- Shared package `ntt_pkg`:
  - function `bitrev(value, width)`.
  - enum `bank_state_t` {EMPTY, FILLING, FULL, DRAINING}.
  - Pair type `coef_pair_t` = logic [DATA_WIDTH-1:0] [2].
- One sub-module `reorder_bank`: simple dual-port RAM, P deep, 2×DATA_WIDTH wide, 1-cycle synchronous read. It is instantiated twice.
- Bank FSMs, counters and the credit logic live in the top module.

## Test plan
All scenarios use STAGE_CNT=3 (N=8, P=4); input pairs are k0=(0,4), k1=(2,6), k2=(1,5), k3=(3,7).
- **Single polynomial.**
  - Stimulus: the 4 pairs on consecutive cycles, `out_ready`=1.
  - Response: output (0,4),(1,5),(2,6),(3,7), first `out_valid` 2 cycles after the k3 write, `out_last` on (3,7), `overflow`=0.
- **Backpressure.**
  - Stimulus: the same polynomial; `out_ready` toggles 1,0,0,1,…
  - Response: order and values unchanged, `out` stable through every stall, exactly 4 transfers.
- **Ping-pong.**
  - Stimulus: three polynomials back to back (second with values +8, third +16), `out_ready`=1.
  - Response: 12 pairs in natural order with no output bubble between polynomials, `overflow`=0.
- **Overflow.**
  - Stimulus: `out_ready`=0; three polynomials streamed.
  - Response: the third is dropped, `overflow`=1 and sticky. Raising `out_ready` then yields exactly the first two polynomials intact.
- **Gapped input.**
  - Stimulus: `in_en` pattern 1,0,1,0,0,1,1.
  - Response: identical output to the single-polynomial case.
- **Reset mid-fill.**
  - Stimulus: `rst` pulsed after k1; then a full polynomial sent.
  - Response: outputs 0 during `rst`; the partial polynomial is never output; the new polynomial is output correctly.

Source files
------------

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared types and helpers for the NTT datapath blocks:
//               bank state encoding, coefficient pair type, bit reversal.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 3
`endif

package ntt_pkg;

    // Lifecycle of one ping-pong buffer bank
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // One butterfly pair: [0] = a[r], [1] = a[r+P]
    typedef logic [`DATA_WIDTH-1:0] coef_pair_t [2];

    // Reverse the low 'width' bits of 'value'; upper bits return zero
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < width; i++) begin
            result[5'(i)] = value[5'(width - 1 - i)];
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// ============================================================================
// Module      : reorder_bank
// Description : Simple dual-port RAM holding one polynomial of coefficient
//               pairs; one write port, one read port, 1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================

module reorder_bank
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 2
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [2*DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: data register holds its value until the next read
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_out_reorder.sv
`default_nettype none
// ============================================================================
// Module      : ntt_out_reorder
// Description : Ping-pong reorder buffer converting the NTT bit-reversed pair
//               stream into natural pair order over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================

module ntt_out_reorder
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STAGE_CNT  = `NTT_STAGE_CNT,
    parameter int ADDR_W     = STAGE_CNT - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_en,
    input  logic [DATA_WIDTH-1:0] in [2],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out [2],
    output logic                  out_last,
    output logic                  overflow
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    bank_state_t             r_bank_state [2];
    bank_state_t             w_bank_next  [2];
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [ADDR_W-1:0]       r_wr_cnt;
    logic [ADDR_W-1:0]       r_rd_cnt;
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic                    r_s1_bank;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [DATA_WIDTH-1:0]   r_out [2];
    logic                    r_overflow;

    logic                    w_wr_accept;
    logic                    w_wr_wrap;
    logic                    w_rd_issue;
    logic                    w_rd_wrap;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_credit_ok;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic [2*DATA_WIDTH-1:0] w_wr_data;
    logic [2*DATA_WIDTH-1:0] w_rd_data [2];
    logic [2*DATA_WIDTH-1:0] w_s1_data;

    // Accept only into a bank that is still collecting; a bank released this
    // cycle still reads DRAINING here, so same-cycle input is dropped.
    assign w_wr_accept = in_en && ((r_bank_state[r_wr_bank] == EMPTY) ||
                                   (r_bank_state[r_wr_bank] == FILLING));
    assign w_wr_wrap   = w_wr_accept && (r_wr_cnt == C_LAST_ADDR);
    assign w_wr_addr   = ADDR_W'(bitrev(32'(r_wr_cnt), ADDR_W));
    assign w_wr_data   = {in[1], in[0]};

    // Two pairs may be in flight (RAM read register + output register); a new
    // read is allowed unless both are occupied and nothing leaves this cycle.
    assign w_xfer      = r_out_valid && out_ready;
    assign w_credit_ok = !(r_s1_valid && r_out_valid && !w_xfer);
    assign w_rd_issue  = ((r_bank_state[r_rd_bank] == FULL) ||
                          (r_bank_state[r_rd_bank] == DRAINING)) && w_credit_ok;
    assign w_rd_wrap   = (r_rd_cnt == C_LAST_ADDR);
    assign w_load      = r_s1_valid && (!r_out_valid || out_ready);
    assign w_s1_data   = w_rd_data[r_s1_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   (w_wr_accept && (r_wr_bank == 1'(b))),
            .wr_addr (w_wr_addr),
            .wr_data (w_wr_data),
            .rd_en   (w_rd_issue && (r_rd_bank == 1'(b))),
            .rd_addr (r_rd_cnt),
            .rd_data (w_rd_data[b])
        );
    end

    // Bank state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_state[0] <= EMPTY;
            r_bank_state[1] <= EMPTY;
        end else begin
            r_bank_state <= w_bank_next;
        end
    end

    // Bank next-state: writer and reader never touch the same bank
    always_comb begin
        w_bank_next = r_bank_state;
        if (w_wr_accept) begin
            if (w_wr_wrap) begin
                w_bank_next[r_wr_bank] = FULL;
            end else if (r_bank_state[r_wr_bank] == EMPTY) begin
                w_bank_next[r_wr_bank] = FILLING;
            end
        end
        if (w_rd_issue) begin
            if (w_rd_wrap) begin
                w_bank_next[r_rd_bank] = EMPTY;
            end else if (r_bank_state[r_rd_bank] == FULL) begin
                w_bank_next[r_rd_bank] = DRAINING;
            end
        end
    end

    // Write/read counters, bank pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_wrap) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (in_en && !w_wr_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_wrap) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    // Read-stage tracking and output register with stall hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_bank   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out[0]    <= '0;
            r_out[1]    <= '0;
        end else begin
            if (w_rd_issue) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= w_rd_wrap;
                r_s1_bank  <= r_rd_bank;
            end else if (w_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_last  <= r_s1_last;
                r_out[0]    <= w_s1_data[DATA_WIDTH-1:0];
                r_out[1]    <= w_s1_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out[0]    = r_out[0];
    assign out[1]    = r_out[1];
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ntt_out_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_out_reorder
// Description : Directed self-checking bench for ntt_out_reorder (N=8, P=4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ntt_out_reorder;

    localparam int DW = 16;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_en;
    logic [DW-1:0] din [2];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout [2];
    logic          out_last;
    logic          overflow;

    int            cyc    = 0;
    int            errors = 0;
    int            checks = 0;
    logic [32:0]   rx_q [$];
    int            rx_cyc [$];
    bit            stab_en    = 1'b0;
    bit            stall_prev = 1'b0;
    logic [32:0]   prev_word;
    int            t_last;

    // Order in which the NTT emits r for k = 0..3
    int            kr [4] = '{0, 2, 1, 3};

    ntt_out_reorder #(
        .DATA_WIDTH (DW),
        .STAGE_CNT  (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] pk(input int lo, input int hi, input bit last);
        return {last, 16'(hi), 16'(lo)};
    endfunction

    // Monitor: capture transfers and verify hold during stalls
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stab_en && stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'({out_last, dout[1], dout[0]}), 64'(prev_word));
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = {out_last, dout[1], dout[0]};
            if (out_valid && out_ready) begin
                rx_q.push_back({out_last, dout[1], dout[0]});
                rx_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_pair(input int k, input int base);
        in_en  = 1'b1;
        din[0] = 16'(kr[k] + base);
        din[1] = 16'(kr[k] + 4 + base);
        tick();
        in_en  = 1'b0;
    endtask

    task automatic send_poly(input int base);
        for (int k = 0; k < 4; k++) send_pair(k, base);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        check({tag, "_rst_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_rst_last"}, 64'(out_last), 64'(0));
        check({tag, "_rst_data"}, 64'({dout[1], dout[0]}), 64'(0));
        check({tag, "_rst_ovf"}, 64'(overflow), 64'(0));
        rst = 1'b0;
        rx_q.delete();
        rx_cyc.delete();
    endtask

    // Bounded wait for n transfers, then confirm nothing extra appears
    task automatic wait_rx(input string tag, input int n);
        for (int i = 0; i < 300 && rx_q.size() < n; i++) tick();
        idle(10);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_poly(input string tag, input int base, input int idx0);
        for (int j = 0; j < 4; j++) begin
            logic [32:0] got;
            got = (idx0 + j < rx_q.size()) ? rx_q[idx0 + j] : 33'h0;
            check($sformatf("%s_p%0d", tag, j), 64'(got), 64'(pk(base + j, base + j + 4, j == 3)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_en     = 1'b0;
        din[0]    = '0;
        din[1]    = '0;
        out_ready = 1'b0;

        // Single polynomial, latency and ordering
        do_reset("single");
        out_ready = 1'b1;
        send_poly(0);
        t_last = cyc;
        wait_rx("single", 4);
        check_poly("single", 0, 0);
        check("single_latency", 64'(rx_cyc.size() > 0 ? rx_cyc[0] : -1), 64'(t_last + 2));
        check("single_burst", 64'(rx_cyc.size() == 4 ? rx_cyc[3] - rx_cyc[0] : -1), 64'(3));
        check("single_ovf", 64'(overflow), 64'(0));

        // Backpressure with ready pattern 1,0,0,1
        do_reset("bp");
        stab_en = 1'b1;
        fork
            send_poly(0);
            for (int i = 0; i < 40; i++) begin
                out_ready = ((i % 4) == 0) || ((i % 4) == 3);
                tick();
            end
        join
        out_ready = 1'b1;
        wait_rx("bp", 4);
        check_poly("bp", 0, 0);
        check("bp_ovf", 64'(overflow), 64'(0));
        stab_en = 1'b0;

        // Ping-pong: three polynomials back to back
        do_reset("pp");
        out_ready = 1'b1;
        send_poly(0);
        send_poly(8);
        send_poly(16);
        wait_rx("pp", 12);
        check_poly("pp0", 0, 0);
        check_poly("pp1", 8, 4);
        check_poly("pp2", 16, 8);
        check("pp_nobubble", 64'(rx_cyc.size() == 12 ? rx_cyc[11] - rx_cyc[0] : -1), 64'(11));
        check("pp_ovf", 64'(overflow), 64'(0));

        // Overflow: consumer stalled while three polynomials arrive
        do_reset("ovf");
        stab_en   = 1'b1;
        out_ready = 1'b0;
        send_poly(0);
        send_poly(8);
        check("ovf_before_third", 64'(overflow), 64'(0));
        send_poly(16);
        idle(5);
        check("ovf_set", 64'(overflow), 64'(1));
        check("ovf_no_xfer", 64'(rx_q.size()), 64'(0));
        out_ready = 1'b1;
        wait_rx("ovf", 8);
        check_poly("ovf0", 0, 0);
        check_poly("ovf1", 8, 4);
        check("ovf_sticky", 64'(overflow), 64'(1));
        stab_en = 1'b0;

        // Gapped input: in_en pattern 1,0,1,0,0,1,1
        do_reset("gap");
        out_ready = 1'b1;
        send_pair(0, 0);
        idle(1);
        send_pair(1, 0);
        idle(2);
        send_pair(2, 0);
        send_pair(3, 0);
        wait_rx("gap", 4);
        check_poly("gap", 0, 0);
        check("gap_ovf", 64'(overflow), 64'(0));

        // Reset mid-fill discards the partial polynomial
        do_reset("mid");
        out_ready = 1'b1;
        send_pair(0, 40);
        send_pair(1, 40);
        idle(3);
        check("mid_no_partial", 64'(rx_q.size()), 64'(0));
        do_reset("mid2");
        send_poly(0);
        wait_rx("mid", 4);
        check_poly("mid", 0, 0);
        check("mid_ovf", 64'(overflow), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
